activation_deskew: RTL

ACTIVATION_DESKEW -- requirements
Module: activation_deskew

---
 rtl/activation_deskew_pkg.sv | 25 ++
 rtl/activation_deskew_act_col_fifo.sv | 82 ++++++++
 rtl/activation_deskew.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/activation_deskew_pkg.sv
// -----------------------------------------------------------------------------
// activation_deskew_pkg
// Shared definitions for the activation deskew block: sample format, the
// saturation bounds used by the leaky-ReLU stage, and the tile FSM states.
// No ports; imported by activation_deskew and act_col_fifo.
// -----------------------------------------------------------------------------
package activation_deskew_pkg;

    // Sample format: signed Q8.8
    localparam int DATA_W   = 16;
    localparam int FRAC_W   = 8;
    localparam int NUM_COLS = 4;

    // Clamp range for the negative (leaky) branch
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    // Tile-level progress: waiting for data, collecting rows, one-cycle done
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } tile_state_e;

endpackage

// File: rtl/activation_deskew_act_col_fifo.sv
// -----------------------------------------------------------------------------
// act_col_fifo
// Single-column synchronous FIFO used to realign skewed activation columns.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push_in           - write push_data_in (ignored when full unless popping)
//   push_data_in      - sample to store
//   pop_in            - discard the head entry (ignored when empty)
//   head_out          - oldest stored sample
//   full_out          - FIFO holds DEPTH entries
//   empty_out         - FIFO holds no entries
// -----------------------------------------------------------------------------
module act_col_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_in,
    input  logic [DATA_W-1:0] push_data_in,
    input  logic              pop_in,
    output logic [DATA_W-1:0] head_out,
    output logic              full_out,
    output logic              empty_out
);
    import activation_deskew_pkg::*;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full_out  = (count_q == (AW+1)'(DEPTH));
    assign empty_out = (count_q == '0);
    assign head_out  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle,
    // so the slot being vacated is reused and the count stays put.
    assign do_pop  = pop_in && !empty_out;
    assign do_push = push_in && (!full_out || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_in;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/activation_deskew.sv
// -----------------------------------------------------------------------------
// activation_deskew
// Applies a leaky-ReLU to four skewed activation columns, realigns them in
// per-column FIFOs and presents complete rows for writeback, counting rows
// per tile and pulsing tile_done_out after the last row of each tile.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   act_data_in_1..4         - signed Q8.8 column samples
//   act_valid_in_1..4        - per-column sample strobes
//   leak_factor              - unsigned Q8.8 slope for negative samples
//   err_clear                - clears the sticky overflow flag
//   row_data_out             - column 1 in the low slice .. column 4 in the top
//   row_valid_out            - all four columns have a sample queued
//   row_ready_in             - writeback accepts the presented row
//   row_idx_out              - index of the presented row within its tile
//   tile_done_out            - one-cycle pulse after a tile's last row
//   overflow_err             - sticky: a column sample was dropped
// -----------------------------------------------------------------------------
module activation_deskew #(
    parameter int DATA_W     = activation_deskew_pkg::DATA_W,
    parameter int FRAC_W     = activation_deskew_pkg::FRAC_W,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_ROWS   = 4,
    localparam int IDX_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     act_data_in_1,
    input  logic [DATA_W-1:0]     act_data_in_2,
    input  logic [DATA_W-1:0]     act_data_in_3,
    input  logic [DATA_W-1:0]     act_data_in_4,
    input  logic                  act_valid_in_1,
    input  logic                  act_valid_in_2,
    input  logic                  act_valid_in_3,
    input  logic                  act_valid_in_4,
    input  logic [DATA_W-1:0]     leak_factor,
    input  logic                  err_clear,
    output logic [4*DATA_W-1:0]   row_data_out,
    output logic                  row_valid_out,
    input  logic                  row_ready_in,
    output logic [IDX_W-1:0]      row_idx_out,
    output logic                  tile_done_out,
    output logic                  overflow_err
);
    import activation_deskew_pkg::*;

    localparam int PW = 2*DATA_W + 1;
    localparam logic signed [PW-1:0] SAT_HI = PW'(SAT_MAX);
    localparam logic signed [PW-1:0] SAT_LO = PW'(SAT_MIN);

    logic [DATA_W-1:0]        col_in [4];
    logic [3:0]               col_vld_in;

    logic signed [PW-1:0]     ext_x   [4];
    logic signed [PW-1:0]     ext_l   [4];
    logic signed [PW-1:0]     prod    [4];
    logic signed [PW-1:0]     shifted [4];

    logic [DATA_W-1:0]        s1_data_d [4];
    logic [DATA_W-1:0]        s1_data_q [4];
    logic [3:0]               s1_valid_d, s1_valid_q;

    logic [DATA_W-1:0]        fifo_head [4];
    logic [3:0]               fifo_full;
    logic [3:0]               fifo_empty;
    logic [3:0]               col_ovf;
    logic                     row_pop;

    logic [IDX_W-1:0]         row_idx_d, row_idx_q;
    logic                     overflow_err_d, overflow_err_q;
    tile_state_e              state_d, state_q;

    assign col_in[0]  = act_data_in_1;
    assign col_in[1]  = act_data_in_2;
    assign col_in[2]  = act_data_in_3;
    assign col_in[3]  = act_data_in_4;
    assign col_vld_in = {act_valid_in_4, act_valid_in_3, act_valid_in_2, act_valid_in_1};

    // Stage 1 leaky-ReLU. The product is formed one bit wider than a full
    // DATA_W x DATA_W product so the zero-extended factor stays positive;
    // the arithmetic shift therefore rounds toward minus infinity.
    always_comb begin
        s1_valid_d = col_vld_in;
        for (int k = 0; k < 4; k++) begin
            ext_x[k]   = {{(DATA_W+1){col_in[k][DATA_W-1]}}, col_in[k]};
            ext_l[k]   = {{(DATA_W+1){1'b0}}, leak_factor};
            prod[k]    = ext_x[k] * ext_l[k];
            shifted[k] = prod[k] >>> FRAC_W;
            if (!col_in[k][DATA_W-1]) begin
                s1_data_d[k] = col_in[k];
            end else if (shifted[k] > SAT_HI) begin
                s1_data_d[k] = SAT_HI[DATA_W-1:0];
            end else if (shifted[k] < SAT_LO) begin
                s1_data_d[k] = SAT_LO[DATA_W-1:0];
            end else begin
                s1_data_d[k] = shifted[k][DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                s1_data_q[k] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            for (int k = 0; k < 4; k++) begin
                s1_data_q[k] <= s1_data_d[k];
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_col
        act_col_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .push_in      (s1_valid_q[k]),
            .push_data_in (s1_data_q[k]),
            .pop_in       (row_pop),
            .head_out     (fifo_head[k]),
            .full_out     (fifo_full[k]),
            .empty_out    (fifo_empty[k])
        );
    end

    // Outputs are forced low while rst is asserted so nothing leaks out
    // before the registers have actually been cleared.
    assign row_valid_out = !rst && (fifo_empty == 4'b0000);
    assign row_pop       = row_valid_out && row_ready_in;

    always_comb begin
        row_data_out = '0;
        if (row_valid_out) begin
            for (int k = 0; k < 4; k++) begin
                row_data_out[k*DATA_W +: DATA_W] = fifo_head[k];
            end
        end
    end

    // A push is lost only when its FIFO is full and no row leaves this cycle.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            col_ovf[k] = s1_valid_q[k] && fifo_full[k] && !row_pop;
        end
    end

    // A new overflow wins over a simultaneous clear.
    always_comb begin
        overflow_err_d = overflow_err_q;
        if (|col_ovf) begin
            overflow_err_d = 1'b1;
        end else if (err_clear) begin
            overflow_err_d = 1'b0;
        end
    end

    always_comb begin
        row_idx_d = row_idx_q;
        if (row_pop) begin
            if (row_idx_q == IDX_W'(NUM_ROWS-1)) begin
                row_idx_d = '0;
            end else begin
                row_idx_d = row_idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|s1_valid_q) state_d = ST_ACTIVE;
            ST_ACTIVE: if (row_pop && (row_idx_q == IDX_W'(NUM_ROWS-1))) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            row_idx_q      <= '0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_idx_q      <= row_idx_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign row_idx_out   = row_idx_q;
    assign overflow_err  = overflow_err_q;
    assign tile_done_out = !rst && (state_q == ST_DONE);

endmodule
